// File: rtl/inst_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I/RV64I decode definitions: instruction format enum, base opcode
// constants, the width-independent part of the decoded bundle, and small
// helper functions used by the decode stage.
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Format classification; encoding is fixed because it is visible on out_type.
    typedef enum logic [2:0] {
        INST_R       = 3'd0,
        INST_I       = 3'd1,
        INST_S       = 3'd2,
        INST_B       = 3'd3,
        INST_U       = 3'd4,
        INST_J       = 3'd5,
        INST_ILLEGAL = 3'd7
    } inst_type_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // XLEN-independent decoded fields; PC and immediate are added by the
    // stage itself because their width depends on its parameter.
    typedef struct packed {
        inst_type_e  itype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        rd_we;
    } dec_fields_t;

    function automatic inst_type_e decode_type(input logic [6:0] opcode);
        inst_type_e t;
        case (opcode)
            OP_REG:                                          t = INST_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:   t = INST_I;
            OP_STORE:                                        t = INST_S;
            OP_BRANCH:                                       t = INST_B;
            OP_LUI, OP_AUIPC:                                t = INST_U;
            OP_JAL:                                          t = INST_J;
            default:                                         t = INST_ILLEGAL;
        endcase
        // Compressed-quadrant encodings are never valid in this base-ISA stage.
        if (opcode[1:0] != 2'b11) begin
            t = INST_ILLEGAL;
        end
        return t;
    endfunction

    // Only formats that produce a result write rd, and x0 is never written.
    function automatic logic writes_rd(input inst_type_e t, input logic [4:0] rd);
        return ((t == INST_R) || (t == INST_I) || (t == INST_U) || (t == INST_J))
               && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// -----------------------------------------------------------------------------
// inst_decode_stage_if
// Handshake/data bundle around the decode stage.
//   Fetch side     : in_valid, in_ready, in_inst[31:0], in_pc[XLEN-1:0]
//   Downstream side: out_valid, out_ready, out_pc, out_type, out_imm, out_rs1,
//                    out_rs2, out_rd, out_funct3, out_funct7, out_rd_we,
//                    out_illegal
// Modports: slave = the decode stage, master = its environment.
// -----------------------------------------------------------------------------
interface inst_decode_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [XLEN-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    inst_type_e        out_type;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic              out_rd_we;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_type, out_imm, out_rs1,
               out_rs2, out_rd, out_funct3, out_funct7, out_rd_we, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_type, out_imm, out_rs1,
               out_rs2, out_rd, out_funct3, out_funct7, out_rd_we, out_illegal
    );
endinterface

// File: rtl/inst_decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator.
//   i_inst [31:7]   instruction bits above the opcode
//   i_type          decoded format
//   o_imm  [XLEN]   immediate, sign-extended from inst[31]; 0 for R/ILLEGAL
// -----------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_inst,
    input  inst_type_e      i_type,
    output logic [XLEN-1:0] o_imm
);
    logic [31:0] w_imm32;

    // Every format's immediate fits in 32 bits with inst[31] as its top bit,
    // so one sign-extending cast covers both XLEN=32 and XLEN=64.
    always_comb begin
        // NOTE: default first so no path through the case leaves w_imm32 unassigned (no latch).
        w_imm32 = '0;
        case (i_type)
            INST_I: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            INST_S: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            INST_B: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                               i_inst[30:25], i_inst[11:8], 1'b0};
            INST_U: w_imm32 = {i_inst[31:12], 12'b0};
            INST_J: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                               i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/inst_decode_stage.sv
// -----------------------------------------------------------------------------
// inst_decode_stage
// Registered RV32I/RV64I decode stage with a one-entry skid buffer.
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset (priority over flush)
//   flush  synchronous discard of everything held
//   bus    inst_decode_stage_if.slave: fetch-side in_* handshake and
//          downstream out_* handshake plus decoded fields
// Storage is an output register O and a skid register K. in_ready is simply
// !K.valid, so it never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module inst_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    inst_decode_stage_if.slave  bus
);
    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("inst_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } bundle_t;

    inst_type_e      w_type;
    logic [XLEN-1:0] w_imm;
    bundle_t         w_dec;
    logic            w_accept;
    logic            w_consume;

    bundle_t         r_o;
    bundle_t         r_k;
    logic            r_o_valid;
    logic            r_k_valid;

    assign w_type = decode_type(bus.in_inst[6:0]);

    imm_gen #(
        .XLEN   (XLEN)
    ) u_imm_gen (
        .i_inst (bus.in_inst[31:7]),
        .i_type (w_type),
        .o_imm  (w_imm)
    );

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = bus.in_pc;
        w_dec.imm      = w_imm;
        w_dec.f.itype  = w_type;
        w_dec.f.rd     = bus.in_inst[11:7];
        w_dec.f.funct3 = bus.in_inst[14:12];
        w_dec.f.rs1    = bus.in_inst[19:15];
        w_dec.f.rs2    = bus.in_inst[24:20];
        w_dec.f.funct7 = bus.in_inst[31:25];
        w_dec.f.rd_we  = writes_rd(w_type, bus.in_inst[11:7]);
    end

    assign w_accept  = bus.in_valid && !r_k_valid;
    assign w_consume = r_o_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so out_* read as zero/type R after reset.
            r_o       <= '0;
            r_k       <= '0;
            r_o_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else if (flush) begin
            // Data is left as-is; only the valid bits matter once cleared.
            r_o_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every test below sees pre-edge state.
            if (w_accept && (!r_o_valid || w_consume)) begin
                // O free or draining this edge: new item goes straight to O.
                r_o       <= w_dec;
                r_o_valid <= 1'b1;
            end else if (w_consume && r_k_valid) begin
                // K is full (so nothing was accepted): promote it into O.
                r_o       <= r_k;
                r_o_valid <= 1'b1;
                r_k_valid <= 1'b0;
            end else if (w_consume) begin
                r_o_valid <= 1'b0;
            end

            if (w_accept && r_o_valid && !w_consume) begin
                r_k       <= w_dec;
                r_k_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = !r_k_valid;
    assign bus.out_valid   = r_o_valid;
    assign bus.out_pc      = r_o.pc;
    assign bus.out_imm     = r_o.imm;
    assign bus.out_type    = r_o.f.itype;
    assign bus.out_rs1     = r_o.f.rs1;
    assign bus.out_rs2     = r_o.f.rs2;
    assign bus.out_rd      = r_o.f.rd;
    assign bus.out_funct3  = r_o.f.funct3;
    assign bus.out_funct7  = r_o.f.funct7;
    assign bus.out_rd_we   = r_o.f.rd_we;
    assign bus.out_illegal = (r_o.f.itype == INST_ILLEGAL);
endmodule

// File: tb/tb_inst_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_stage
// Drives identical stimulus into an XLEN=32 and an XLEN=64 instance. The
// driver pushes hand-computed expectations into one queue per instance when
// an instruction is accepted; per-instance monitors pop and compare on every
// output handshake and also check that held outputs stay stable.
// -----------------------------------------------------------------------------
module tb_inst_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] PC_HI = 32'hA5A5_0001;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t q32[$];
    exp_t q64[$];
    int   pop32[$];

    inst_decode_stage_if #(.XLEN(32)) bus32 ();
    inst_decode_stage_if #(.XLEN(64)) bus64 ();

    inst_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
    inst_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e,
                       input logic [63:0] pc_exp, input logic [63:0] imm_exp,
                       input logic [63:0] pc_act, input logic [63:0] imm_act,
                       input logic [2:0] typ, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                       input logic we, input logic ill);
        check({tag, "_pc"},      pc_act,      pc_exp);
        check({tag, "_type"},    64'(typ),    64'(e.typ));
        check({tag, "_imm"},     imm_act,     imm_exp);
        check({tag, "_rs1"},     64'(rs1),    64'(e.rs1));
        check({tag, "_rs2"},     64'(rs2),    64'(e.rs2));
        check({tag, "_rd"},      64'(rd),     64'(e.rd));
        check({tag, "_funct3"},  64'(f3),     64'(e.f3));
        check({tag, "_funct7"},  64'(f7),     64'(e.f7));
        check({tag, "_rd_we"},   64'(we),     64'(e.we));
        check({tag, "_illegal"}, 64'(ill),    64'(e.typ == 3'd7));
    endtask

    // ---------------- monitors ----------------
    logic        hold32 = 1'b0;
    logic [31:0] hold_pc, hold_imm;
    logic [2:0]  hold_type;

    always @(negedge clk) begin
        exp_t e;
        if (hold32) begin
            check("hold_valid", 64'(bus32.out_valid), 64'd1);
            check("hold_pc",    64'(bus32.out_pc),    64'(hold_pc));
            check("hold_imm",   64'(bus32.out_imm),   64'(hold_imm));
            check("hold_type",  64'(bus32.out_type),  64'(hold_type));
        end
        hold32    = rst_n && !flush && bus32.out_valid && !bus32.out_ready;
        hold_pc   = bus32.out_pc;
        hold_imm  = bus32.out_imm;
        hold_type = bus32.out_type;
        if (rst_n && !flush && bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                check("spurious_out32", 64'(q32.size()), 64'd1);
            end else begin
                e = q32.pop_front();
                pop32.push_back(cyc);
                cmp("d32", e, 64'(e.pc), 64'(e.imm), 64'(bus32.out_pc), 64'(bus32.out_imm),
                    bus32.out_type, bus32.out_rs1, bus32.out_rs2, bus32.out_rd,
                    bus32.out_funct3, bus32.out_funct7, bus32.out_rd_we, bus32.out_illegal);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                check("spurious_out64", 64'(q64.size()), 64'd1);
            end else begin
                e = q64.pop_front();
                cmp("d64", e, {PC_HI, e.pc}, {{32{e.imm[31]}}, e.imm}, bus64.out_pc, bus64.out_imm,
                    bus64.out_type, bus64.out_rs1, bus64.out_rs2, bus64.out_rd,
                    bus64.out_funct3, bus64.out_funct7, bus64.out_rd_we, bus64.out_illegal);
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic exp_t mk(input logic [2:0] typ, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [6:0] f7, input logic we);
        exp_t e;
        e.pc = '0; e.typ = typ; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2;
        e.rd = rd; e.f3 = f3; e.f7 = f7; e.we = we;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus32.in_valid = v;  bus64.in_valid = v;
        bus32.in_inst  = inst; bus64.in_inst = inst;
        bus32.in_pc    = pc;  bus64.in_pc    = {PC_HI, pc};
    endtask

    task automatic set_ready(input logic r);
        bus32.out_ready = r;
        bus64.out_ready = r;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction until accepted; expectations are queued at the accepting edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e_in);
        exp_t e;
        logic r32, r64;
        bit   done;
        done = 0;
        e    = e_in;
        e.pc = pc;
        drive(1'b1, inst, pc);
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            r32 = bus32.in_ready;
            r64 = bus64.in_ready;
            @(posedge clk);
            if (r32) begin
                q32.push_back(e);
                if (r64) q64.push_back(e);
                else     check("accept_match64", 64'(r64), 64'd1);
                done = 1;
            end
            #1;
        end
        if (!done) check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_consecutive(input string name);
        int n;
        n = pop32.size();
        if (n < 3) check(name, 64'(n), 64'd3);
        else       check(name, 64'(pop32[n-1] - pop32[n-3]), 64'd2);
    endtask

    // ---------------- stimulus ----------------
    exp_t e_addi, e_sw, e_beq, e_lui, e_ill, e_a, e_b, e_c, e_luin;

    initial begin
        e_addi = mk(3'd1, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd1, 3'd0, 7'h7F, 1'b1);
        e_sw   = mk(3'd2, 32'h0000_0008, 5'd1, 5'd2,  5'd8, 3'd2, 7'h00, 1'b0);
        e_beq  = mk(3'd3, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd29, 3'd0, 7'h7F, 1'b0);
        e_lui  = mk(3'd4, 32'h1234_5000, 5'd8, 5'd3,  5'd5, 3'd5, 7'h09, 1'b1);
        e_ill  = mk(3'd7, 32'h0000_0000, 5'd0, 5'd0,  5'd0, 3'd0, 7'h00, 1'b0);
        e_a    = mk(3'd1, 32'h0000_0005, 5'd0, 5'd5,  5'd2, 3'd0, 7'h00, 1'b1);
        e_b    = mk(3'd0, 32'h0000_0000, 5'd0, 5'd0,  5'd0, 3'd0, 7'h00, 1'b0);
        e_c    = mk(3'd5, 32'h0000_0008, 5'd0, 5'd8,  5'd1, 3'd0, 7'h00, 1'b1);
        e_luin = mk(3'd4, 32'h8000_0000, 5'd0, 5'd0,  5'd5, 3'd0, 7'h40, 1'b1);

        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        set_ready(1'b0);
        cycles(3);
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready32",  64'(bus32.in_ready),  64'd1);
        check("rst_type32",      64'(bus32.out_type),  64'd0);
        check("rst_imm32",       64'(bus32.out_imm),   64'd0);
        check("rst_pc32",        64'(bus32.out_pc),    64'd0);
        check("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        check("rst_imm64",       bus64.out_imm,        64'd0);

        // Single addi, one-cycle latency
        set_ready(1'b1);
        send(32'hFFF0_0093, 32'h0000_0100, e_addi);
        check("latency_valid", 64'(bus32.out_valid), 64'd1);
        idle();
        cycles(2);

        // Back-to-back sw, beq, lui at full throughput
        send(32'h0020_A423, 32'h0000_0104, e_sw);
        send(32'hFE00_0EE3, 32'h0000_0108, e_beq);
        send(32'h1234_52B7, 32'h0000_010C, e_lui);
        idle();
        cycles(2);
        check_consecutive("burst_throughput");

        // Illegal encodings are forwarded
        send(32'h0000_007F, 32'h0000_0110, e_ill);
        send(32'h0000_0000, 32'h0000_0114, e_ill);
        idle();
        cycles(2);

        // Backpressure: A in O, B in K, C held
        set_ready(1'b0);
        send(32'h0050_0113, 32'h0000_0200, e_a);
        send(32'h0000_0033, 32'h0000_0204, e_b);
        check("bp_in_ready_full", 64'(bus32.in_ready), 64'd0);
        check("bp_out_pc_is_a",   64'(bus32.out_pc),   64'h200);
        drive(1'b1, 32'h0080_00EF, 32'h0000_0208);
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            check("bp_c_held", 64'(bus32.in_ready), 64'd0);
        end
        set_ready(1'b1);
        send(32'h0080_00EF, 32'h0000_0208, e_c);
        idle();
        cycles(2);
        check_consecutive("bp_drain_order");

        // Flush with O and K full, an incoming instruction and out_ready high
        set_ready(1'b0);
        send(32'h0050_0113, 32'h0000_0300, e_a);
        send(32'h0080_00EF, 32'h0000_0304, e_c);
        drive(1'b1, 32'h1234_52B7, 32'h0000_0308);
        flush = 1'b1;
        set_ready(1'b1);
        @(posedge clk);
        q32.delete();
        q64.delete();
        #1;
        flush = 1'b0;
        idle();
        check("flush_out_valid32", 64'(bus32.out_valid), 64'd0);
        check("flush_in_ready32",  64'(bus32.in_ready),  64'd1);
        check("flush_out_valid64", 64'(bus64.out_valid), 64'd0);
        check("flush_in_ready64",  64'(bus64.in_ready),  64'd1);
        send(32'h0020_A423, 32'h0000_030C, e_sw);
        idle();
        cycles(2);

        // Negative U immediate (sign extension visible at XLEN=64)
        send(32'h8000_02B7, 32'h0000_0400, e_luin);
        idle();
        cycles(2);

        // Reset wins over flush and clears data registers
        set_ready(1'b0);
        send(32'h1234_52B7, 32'h0000_0500, e_lui);
        idle();
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        q32.delete();
        q64.delete();
        #1;
        rst_n = 1'b1;
        flush = 1'b0;
        check("rst2_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst2_in_ready",  64'(bus32.in_ready),  64'd1);
        check("rst2_pc",        64'(bus32.out_pc),    64'd0);
        check("rst2_type",      64'(bus32.out_type),  64'd0);
        check("rst2_pc64",      bus64.out_pc,         64'd0);

        set_ready(1'b1);
        for (int t = 0; t < 20 && (q32.size() != 0 || q64.size() != 0); t++) begin
            cycles(1);
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered RV32I/RV64I decode stage that sits between fetch and the register-read/execute stage. It classifies each instruction word into a format type, generates the sign-extended immediate and extracts register and funct fields. It flags illegal encodings and passes results downstream through a valid/ready interface with a one-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. A pipeline flush discards everything in flight.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 and 64 are legal; any other value is an elaboration error.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous discard of all held instructions
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept an instruction
- `in_inst`  in  32  instruction word
- `in_pc`  in  XLEN  instruction address
- `out_valid`  out  1  decoded instruction available
- `out_ready`  in  1  downstream accepts
- `out_pc`  out  XLEN  passthrough PC
- `out_type`  out  3  `inst_type_e`: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
- `out_imm`  out  XLEN  sign-extended immediate
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register fields
- `out_funct3`  out  3; `out_funct7`  out  7
- `out_rd_we`  out  1  destination written (type R/I/U/J and rd≠0)
- `out_illegal`  out  1  equals (out_type==ILLEGAL)

## Operation
- Opcode map (inst[6:0]):
  - 0110011 → R
  - 0010011, 0000011, 1100111, 0001111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - Any other opcode → ILLEGAL. inst[1:0]≠11 is always ILLEGAL.
- Immediate by type, sign-extended from inst[31] to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}, sign-extended when XLEN=64
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R and ILLEGAL: 0
- Register and funct fields are raw bit slices, regardless of type.
- ILLEGAL instructions are forwarded with out_illegal=1 and out_rd_we=0. They are never dropped, so execute can trap.
- Storage: one output register (O) and one skid register (K), each with a valid bit. `in_ready = !K.valid`.
- Accept: when in_valid && in_ready:
  - If O is empty, or O is being consumed this cycle, the decode result loads into O.
  - Otherwise it loads into K.
- Consume: when out_valid && out_ready, O is released. If K is valid, K moves into O and K empties.
- A simultaneous accept and consume with K empty loads the new item into O. No bubble occurs.
- Order is strictly preserved. No loss and no duplication.

## Timing
- Latency: instruction accepted in cycle n appears on out_* in cycle n+1, provided O was free or being consumed.
- Throughput: 1 instruction/cycle under continuous out_ready.
- Backpressure:
  - At most 2 instructions are held.
  - in_ready falls the cycle after K fills.
  - in_ready rises the cycle after K drains.
- Reset (rst_n=0 at a clock edge): O.valid=0, K.valid=0, all data registers=0 (out_type=R, out_imm=0, out_pc=0). After that edge, out_valid=0 and in_ready=1.
- Reset mid-operation drops all held instructions; nothing is replayed.
- Flush: at the edge where flush=1, O.valid and K.valid clear.
  - Any in_valid in that cycle is not captured, and any out_ready in that cycle is ignored.
  - Next cycle: out_valid=0, in_ready=1.
  - Reset has priority over flush.
- out_* are stable while out_valid && !out_ready.

## Structure
- Package `riscv_pkg`:
  - `inst_type_e` (3-bit, fixed encoding above)
  - opcode constants (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM)
  - decoded-bundle struct, used by both O and K
- Sub-module `imm_gen`: combinational; (inst, type) → XLEN immediate. It is instantiated once on the input path, before the registers.

## Test plan
- `0xFFF00093` (addi x1,x0,-1), out_ready=1 → next cycle: type=I, imm=0xFFFFFFFF, rd=1, rs1=0, rd_we=1, illegal=0.
- Back-to-back `0x0020A423` (sw x2,8(x1)), `0xFE000EE3` (beq x0,x0,-4), `0x123452B7` (lui x5,0x12345):
  - sw → S, imm=8, rd_we=0
  - beq → B, imm=0xFFFFFFFC
  - lui → U, imm=0x12345000, rd=5
  - one instruction per cycle
- `0x0000007F` and `0x00000000` → type=ILLEGAL, illegal=1, imm=0, rd_we=0; both forwarded.
- Backpressure: out_ready=0 while driving instructions A, B, C:
  - A sits in O, B in K, in_ready=0, C is held.
  - Raise out_ready → outputs A, B, C in order on consecutive cycles, with no duplicates.
- With O and K full, assert flush for 1 cycle while in_valid=1 → next cycle out_valid=0, in_ready=1, and the flush-cycle instruction is never output.
- XLEN=64: addi -1 → imm=0xFFFFFFFFFFFFFFFF; lui with inst[31]=1 (`0x800002B7`) → imm=0xFFFFFFFF80000000.
